// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: arbitration state and
// last-owner encoding used for round-robin tie breaking.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK_D
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of core-side request/response and RAM-side signals around the
// memory port arbiter. slave = arbiter view, master = core + RAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_a;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rd;

  logic                  d_req;
  logic                  d_we;
  logic                  d_lock;
  logic [ADDR_WIDTH-1:0] d_a;
  logic [DATA_WIDTH-1:0] d_wd;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rd;

  logic [ADDR_WIDTH-1:0] m_a;
  logic                  m_we;
  logic [DATA_WIDTH-1:0] m_wd;
  logic [DATA_WIDTH-1:0] m_rd;

  modport slave (
    input  i_req, i_a, d_req, d_we, d_lock, d_a, d_wd, m_rd,
    output i_gnt, i_rvalid, i_rd, d_gnt, d_rvalid, d_rd, m_a, m_we, m_wd
  );

  modport master (
    output i_req, i_a, d_req, d_we, d_lock, d_a, d_wd, m_rd,
    input  i_gnt, i_rvalid, i_rd, d_gnt, d_rvalid, d_rd, m_a, m_we, m_wd
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM sharing between instruction fetch (read-only) and data
// (read/write) requesters: zero-latency round-robin grants plus a D-side lock.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t            state_q, state_d;
  arb_owner_t            last_q, last_d;
  logic                  i_rvalid_q;
  logic                  d_rvalid_q;
  logic [DATA_WIDTH-1:0] i_rd_q;
  logic [DATA_WIDTH-1:0] d_rd_q;

  logic                  i_gnt;
  logic                  d_gnt;
  logic                  d_rd_en;

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst_i) begin
      if (state_q == ARB_LOCK_D) begin
        d_gnt = bus.d_req;
      end else if (bus.i_req && bus.d_req) begin
        i_gnt = (last_q == OWNER_D);
        d_gnt = (last_q == OWNER_I);
      end else begin
        i_gnt = bus.i_req;
        d_gnt = bus.d_req;
      end
    end
  end

  assign d_rd_en = d_gnt & ~bus.d_we;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (i_gnt) begin
      last_d = OWNER_I;
    end else if (d_gnt) begin
      last_d = OWNER_D;
    end
    // The lock bit of every D access decides whether ownership is kept.
    if (d_gnt) begin
      state_d = bus.d_lock ? ARB_LOCK_D : ARB_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      last_q     <= OWNER_D;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rd_q     <= '0;
      d_rd_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_rd_en;
      if (i_gnt) begin
        i_rd_q <= bus.m_rd;
      end
      if (d_rd_en) begin
        d_rd_q <= bus.m_rd;
      end
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.i_rd     = i_rd_q;
  assign bus.d_rd     = d_rd_q;

  // I_A is the idle default so the RAM address bus never floats.
  assign bus.m_a  = d_gnt ? bus.d_a : bus.i_a;
  assign bus.m_we = d_gnt & bus.d_we;
  assign bus.m_wd = bus.d_wd;

endmodule
